// File: rtl/aes128_iter_enc.sv
// Iterative AES-128 encryption engine: one block in flight, ROUNDS_PER_CYCLE rounds per clock,
// round keys expanded on the fly alongside the data path.
module aes128_iter_enc #(
   parameter int unsigned ROUNDS_PER_CYCLE = 1,
   parameter int unsigned ID_W             = 4
) (
   input  logic            Clk,
   input  logic            Rst,
   input  logic            In_Valid,
   output logic            In_Ready,
   input  logic [127:0]    Plain_Text,
   input  logic [127:0]    Key,
   input  logic [ID_W-1:0] In_Id,
   output logic            Out_Valid,
   input  logic            Out_Ready,
   output logic [127:0]    Cipher_Text,
   output logic [ID_W-1:0] Out_Id,
   output logic            Busy
);

   localparam int unsigned RPC      = ROUNDS_PER_CYCLE;
   localparam int unsigned NCYC     = 10 / RPC;
   localparam logic [3:0]  LAST_RND = 4'((NCYC - 1) * RPC + 1);

   if (!(RPC == 1 || RPC == 2 || RPC == 5 || RPC == 10)) begin : g_bad_rpc
      $error("aes128_iter_enc: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
   end

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{~b, 3'b111} -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // Byte i of the block sits at row i%4, column i/4; ShiftRows pulls row r from column c+r.
   function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                              input logic last);
      logic [127:0] sr;
      logic [127:0] mc;
      sr = '0;
      mc = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            sr[127 - 8 * (4 * c + r) -: 8] = sbox(s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8]);
         end
      end
      for (int unsigned c = 0; c < 4; c++) begin
         mc[127 - 32 * c -: 32] = last ? sr[127 - 32 * c -: 32] : mix_col(sr[127 - 32 * c -: 32]);
      end
      return mc ^ rk;
   endfunction

   function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] t, w0, w1, w2, w3;
      t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
      w0 = k[127:96] ^ t;
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0] ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   state_e            state_q, state_d;
   logic [127:0]      st_q, st_d;
   logic [127:0]      rk_q, rk_d;
   logic [7:0]        rcon_q, rcon_d;
   logic [3:0]        rnd_q, rnd_d;
   logic [ID_W-1:0]   tag_q, tag_d;
   logic [127:0]      ct_q, ct_d;
   logic [ID_W-1:0]   oid_q, oid_d;

   for (genvar k = 0; k < RPC; k++) begin : g_rnd
      logic [127:0] st_i, key_i, st_o, key_o;
      logic [7:0]   rc_i, rc_o;
      if (k == 0) begin : g_first
         assign st_i  = st_q;
         assign key_i = rk_q;
         assign rc_i  = rcon_q;
      end else begin : g_next
         assign st_i  = g_rnd[k-1].st_o;
         assign key_i = g_rnd[k-1].key_o;
         assign rc_i  = g_rnd[k-1].rc_o;
      end
      assign key_o = next_key(key_i, rc_i);
      assign rc_o  = xtime(rc_i);
      assign st_o  = enc_round(st_i, key_o, rnd_q == 4'(10 - k));
   end

   assign In_Ready    = !Rst && (state_q == IDLE || (state_q == DONE && Out_Ready));
   assign Out_Valid   = (state_q == DONE);
   assign Busy        = (state_q == RUN);
   assign Cipher_Text = ct_q;
   assign Out_Id      = oid_q;

   always_comb begin
      state_d = state_q;
      st_d    = st_q;
      rk_d    = rk_q;
      rcon_d  = rcon_q;
      rnd_d   = rnd_q;
      tag_d   = tag_q;
      ct_d    = ct_q;
      oid_d   = oid_q;
      unique case (state_q)
         RUN: begin
            st_d   = g_rnd[RPC-1].st_o;
            rk_d   = g_rnd[RPC-1].key_o;
            rcon_d = g_rnd[RPC-1].rc_o;
            rnd_d  = rnd_q + 4'(RPC);
            if (rnd_q == LAST_RND) begin
               ct_d    = g_rnd[RPC-1].st_o;
               oid_d   = tag_q;
               state_d = DONE;
            end
         end
         DONE: begin
            if (Out_Ready) state_d = IDLE;
         end
         default: ;
      endcase
      // An accept in DONE overrides the return to IDLE so back-to-back blocks see no bubble.
      if (In_Valid && In_Ready) begin
         st_d    = Plain_Text ^ Key;
         rk_d    = Key;
         tag_d   = In_Id;
         rcon_d  = 8'h01;
         rnd_d   = 4'd1;
         state_d = RUN;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= IDLE;
         rcon_q  <= '0;
         rnd_q   <= '0;
         ct_q    <= '0;
         oid_q   <= '0;
      end else begin
         state_q <= state_d;
         rcon_q  <= rcon_d;
         rnd_q   <= rnd_d;
         ct_q    <= ct_d;
         oid_q   <= oid_d;
      end
   end

   always_ff @(posedge Clk) begin
      st_q  <= st_d;
      rk_q  <= rk_d;
      tag_q <= tag_d;
   end

endmodule

// File: tb/tb_aes128_iter_enc.sv
// Directed bench for aes128_iter_enc: one instance per legal ROUNDS_PER_CYCLE, all sharing clock,
// reset and data inputs, exercised one after another with FIPS-197 known-answer vectors.
module tb_aes128_iter_enc;

   localparam int NDUT = 4;

   localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [127:0] pt = '0;
   logic [127:0] key = '0;
   logic [3:0]   in_id = '0;
   logic         in_valid  [NDUT];
   logic         out_ready [NDUT];
   logic         in_ready  [NDUT];
   logic         out_valid [NDUT];
   logic         busy      [NDUT];
   logic [127:0] ct        [NDUT];
   logic [3:0]   out_id    [NDUT];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int unsigned R = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
      aes128_iter_enc #(.ROUNDS_PER_CYCLE(R), .ID_W(4)) u_dut (
         .Clk        (clk),
         .Rst        (rst),
         .In_Valid   (in_valid[g]),
         .In_Ready   (in_ready[g]),
         .Plain_Text (pt),
         .Key        (key),
         .In_Id      (in_id),
         .Out_Valid  (out_valid[g]),
         .Out_Ready  (out_ready[g]),
         .Cipher_Text(ct[g]),
         .Out_Id     (out_id[g]),
         .Busy       (busy[g])
      );
   end

   function automatic int ncyc_of(input int j);
      case (j)
         0:       return 10;
         1:       return 5;
         2:       return 2;
         default: return 1;
      endcase
   endfunction

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ov(input int j, output int n);
      n = 0;
      while (out_valid[j] !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic run_block(input int j, input string tag, input logic [127:0] p,
                            input logic [127:0] k, input logic [3:0] id,
                            input logic [127:0] exp, input bit corrupt);
      int n;
      pt = p; key = k; in_id = id; in_valid[j] = 1'b1;
      check({tag, "_inrdy"}, 128'(in_ready[j]), 128'd1);
      tick();
      in_valid[j] = 1'b0;
      if (corrupt) begin
         pt = ~p; key = k ^ 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0; in_id = ~id;
      end
      check({tag, "_busy"}, 128'(busy[j]), 128'd1);
      wait_ov(j, n);
      check({tag, "_lat"}, 128'(n), 128'(ncyc_of(j)));
      check({tag, "_ct"}, ct[j], exp);
      check({tag, "_id"}, 128'(out_id[j]), 128'(id));
      out_ready[j] = 1'b1;
      tick();
      out_ready[j] = 1'b0;
      check({tag, "_ovclr"}, 128'(out_valid[j]), 128'd0);
      check({tag, "_idle"}, 128'(busy[j]), 128'd0);
   endtask

   task automatic back_to_back(input int j, input string tag);
      int n;
      pt = P1; key = K1; in_id = 4'd3; in_valid[j] = 1'b1; out_ready[j] = 1'b1;
      tick();
      pt = P2; key = K2; in_id = 4'd9;
      wait_ov(j, n);
      check({tag, "_b2b_lat1"}, 128'(n), 128'(ncyc_of(j)));
      check({tag, "_b2b_ct1"}, ct[j], C1);
      check({tag, "_b2b_id1"}, 128'(out_id[j]), 128'd3);
      check({tag, "_b2b_ovl"}, 128'(in_ready[j]), 128'd1);
      tick();
      in_valid[j] = 1'b0;
      check({tag, "_b2b_gap"}, 128'(out_valid[j]), 128'd0);
      check({tag, "_b2b_run2"}, 128'(busy[j]), 128'd1);
      wait_ov(j, n);
      check({tag, "_b2b_space"}, 128'(n), 128'(ncyc_of(j)));
      check({tag, "_b2b_ct2"}, ct[j], C2);
      check({tag, "_b2b_id2"}, 128'(out_id[j]), 128'd9);
      tick();
      out_ready[j] = 1'b0;
      check({tag, "_b2b_end"}, 128'(out_valid[j]), 128'd0);
   endtask

   task automatic backpressure(input int j, input string tag);
      int n;
      pt = P2; key = K2; in_id = 4'd6; in_valid[j] = 1'b1;
      tick();
      in_valid[j] = 1'b0;
      wait_ov(j, n);
      check({tag, "_bp_ct"}, ct[j], C2);
      pt = P1; key = K1; in_id = 4'd7; in_valid[j] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check({tag, "_bp_ov"}, 128'(out_valid[j]), 128'd1);
         check({tag, "_bp_hold_ct"}, ct[j], C2);
         check({tag, "_bp_hold_id"}, 128'(out_id[j]), 128'd6);
         check({tag, "_bp_inrdy"}, 128'(in_ready[j]), 128'd0);
      end
      in_valid[j] = 1'b0; out_ready[j] = 1'b1;
      tick();
      out_ready[j] = 1'b0;
      check({tag, "_bp_ovclr"}, 128'(out_valid[j]), 128'd0);
      check({tag, "_bp_idle"}, 128'(busy[j]), 128'd0);
      check({tag, "_bp_inrdy_idle"}, 128'(in_ready[j]), 128'd1);
   endtask

   task automatic reset_mid_run(input int j, input string tag);
      int nr;
      nr = (ncyc_of(j) > 2) ? 2 : ncyc_of(j) - 1;
      pt = P1; key = K1; in_id = 4'd3; in_valid[j] = 1'b1;
      tick();
      in_valid[j] = 1'b0;
      for (int i = 0; i < nr; i++) tick();
      check({tag, "_rst_inrun"}, 128'(busy[j]), 128'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check({tag, "_rst_ov"}, 128'(out_valid[j]), 128'd0);
      check({tag, "_rst_ct"}, ct[j], 128'd0);
      check({tag, "_rst_inrdy"}, 128'(in_ready[j]), 128'd1);
      check({tag, "_rst_busy"}, 128'(busy[j]), 128'd0);
      for (int i = 0; i < ncyc_of(j) + 2; i++) begin
         tick();
         check({tag, "_rst_noov"}, 128'(out_valid[j]), 128'd0);
      end
      run_block(j, {tag, "_rst_kat2"}, P2, K2, 4'd12, C2, 1'b0);
   endtask

   initial begin
      string pfx;
      for (int j = 0; j < NDUT; j++) begin
         in_valid[j] = 1'b0;
         out_ready[j] = 1'b0;
      end
      rst = 1'b1;
      tick();
      tick();
      for (int j = 0; j < NDUT; j++) begin
         pfx = $sformatf("rpc%0d", 10 / ncyc_of(j));
         check({pfx, "_rst_ov0"}, 128'(out_valid[j]), 128'd0);
         check({pfx, "_rst_busy0"}, 128'(busy[j]), 128'd0);
         check({pfx, "_rst_ct0"}, ct[j], 128'd0);
         check({pfx, "_rst_id0"}, 128'(out_id[j]), 128'd0);
         check({pfx, "_rst_inrdy0"}, 128'(in_ready[j]), 128'd0);
      end
      rst = 1'b0;
      tick();
      for (int j = 0; j < NDUT; j++) begin
         pfx = $sformatf("rpc%0d", 10 / ncyc_of(j));
         check({pfx, "_inrdy_after_rst"}, 128'(in_ready[j]), 128'd1);
      end
      for (int j = 0; j < NDUT; j++) begin
         pfx = $sformatf("rpc%0d", 10 / ncyc_of(j));
         run_block(j, {pfx, "_kat1"}, P1, K1, 4'd3, C1, 1'b0);
         run_block(j, {pfx, "_kat2"}, P2, K2, 4'd5, C2, 1'b0);
         run_block(j, {pfx, "_corrupt"}, P1, K1, 4'd11, C1, 1'b1);
         back_to_back(j, pfx);
         backpressure(j, pfx);
         reset_mid_run(j, pfx);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
